// File: rtl/skew_rd_control.sv
// Skewed read-address sequencer: lane i reads num_rows rows starting i cycles after lane 0,
// then holds wr_active over the drain window. Optional macro SKEW_RD_CONTROL_REVERSE_EN adds descending reads.
module skew_rd_control #(
  parameter int WIDTH_HEIGHT = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int MAX_ROWS     = 16,
  parameter int WR_LATENCY   = 18,
  localparam int RW          = $clog2(MAX_ROWS + 1)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic                               abort,
`ifdef SKEW_RD_CONTROL_REVERSE_EN
  input  logic                               reverse,
`endif
  input  logic [ADDR_WIDTH-1:0]              base_addr,
  input  logic [RW-1:0]                      num_rows,
  output logic [WIDTH_HEIGHT-1:0]            rd_en,
  output logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] rd_addr,
  output logic                               wr_active,
  output logic                               busy,
  output logic                               done,
  output logic [1:0]                         dbg_state
);

  localparam int CW = $clog2(WR_LATENCY + MAX_ROWS + WIDTH_HEIGHT + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                             state_q, state_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]              base_q, base_d;
  logic [RW-1:0]                      rows_q, rows_d;
  logic                               rev_q, rev_d, rev_in;
  logic [WIDTH_HEIGHT-1:0]            rd_en_q, rd_en_d;
  logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                               wr_q, wr_d;
  logic                               busy_q, done_q;
  logic [CW-1:0]                      last_rd, last_wr, last_wr_d, off;

`ifdef SKEW_RD_CONTROL_REVERSE_EN
  assign rev_in = reverse;
`else
  assign rev_in = 1'b0;
`endif

  // Count of the final wr_active cycle: WR_LATENCY + R + WIDTH_HEIGHT - 2.
  function automatic logic [CW-1:0] last_wr_f(input logic [RW-1:0] r);
    return CW'(WR_LATENCY) + CW'(r) + CW'(WIDTH_HEIGHT) - CW'(2);
  endfunction

  assign last_rd   = CW'(rows_q) + CW'(WIDTH_HEIGHT) - CW'(2);
  assign last_wr   = last_wr_f(rows_q);
  assign last_wr_d = last_wr_f(rows_d);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    rows_d  = rows_q;
    rev_d   = rev_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          base_d  = base_addr;
          rows_d  = num_rows;
          rev_d   = rev_in;
          cnt_d   = '0;
          state_d = (num_rows == '0) ? DONE : READ;
        end
      end
      READ: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == last_rd) state_d = (cnt_q >= last_wr) ? DONE : DRAIN;
      end
      DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q >= last_wr) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Outputs are computed from the next state/count so they are registered alongside it.
  always_comb begin
    rd_en_d   = '0;
    rd_addr_d = '0;
    off       = '0;
    for (int i = 0; i < WIDTH_HEIGHT; i++) begin
      off = cnt_d - CW'(i);
      if (state_d == READ && cnt_d >= CW'(i) && off < CW'(rows_d)) begin
        rd_en_d[i] = 1'b1;
        rd_addr_d[i*ADDR_WIDTH +: ADDR_WIDTH] = rev_d ? (base_d - ADDR_WIDTH'(off))
                                                      : (base_d + ADDR_WIDTH'(off));
      end
    end
    wr_d = (state_d == READ || state_d == DRAIN) &&
           (cnt_d >= CW'(WR_LATENCY)) && (cnt_d <= last_wr_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      base_q    <= '0;
      rows_q    <= '0;
      rev_q     <= 1'b0;
      rd_en_q   <= '0;
      rd_addr_q <= '0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      rows_q    <= rows_d;
      rev_q     <= rev_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_q      <= wr_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign wr_active = wr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
